sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 52 +++++
 tb/tb_sync_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with wrap-bit pointers, level flags and sticky error flags.
module sync_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4,
  parameter int AFULL_TH  = (1 << ADDR_SIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WINC,
  input  logic [DATA_SIZE-1:0] WDATA,
  input  logic                 RINC,
  input  logic                 CLR_ERR,
  output logic [DATA_SIZE-1:0] RDATA,
  output logic                 WFULL,
  output logic                 REMPTY,
  output logic                 WAFULL,
  output logic                 RAEMPTY,
  output logic [ADDR_SIZE:0]   COUNT,
  output logic                 OVF,
  output logic                 UDF
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0] wptr, rptr;
  logic we, re;
  // Flags come only from registered pointers; the extra MSB separates full from empty.
  assign REMPTY  = wptr == rptr;
  assign WFULL   = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) && (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
  assign COUNT   = wptr - rptr;
  assign WAFULL  = COUNT >= (ADDR_SIZE+1)'(AFULL_TH);
  assign RAEMPTY = COUNT <= (ADDR_SIZE+1)'(AEMPTY_TH);
  assign RDATA   = mem[rptr[ADDR_SIZE-1:0]];
  assign we      = WINC && !WFULL;
  assign re      = RINC && !REMPTY;
  always_ff @(posedge CLK) begin
    if (we) mem[wptr[ADDR_SIZE-1:0]] <= WDATA;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      OVF  <= 1'b0;
      UDF  <= 1'b0;
    end else begin
      wptr <= wptr + (ADDR_SIZE+1)'(we);
      rptr <= rptr + (ADDR_SIZE+1)'(re);
      OVF  <= (WINC && WFULL) || (OVF && !CLR_ERR);
      UDF  <= (RINC && REMPTY) || (UDF && !CLR_ERR);
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;
  logic        CLK = 0, RST = 1, WINC = 0, RINC = 0, CLR_ERR = 0;
  logic [15:0] WDATA = '0, RDATA;
  logic        WFULL, REMPTY, WAFULL, RAEMPTY, OVF, UDF;
  logic [4:0]  COUNT;
  logic [10:0] dut_flags;
  int passed = 0, total = 0;
  logic [15:0] q[$];
  bit m_ovf, m_udf;

  sync_fifo dut (
    .CLK(CLK), .RST(RST), .WINC(WINC), .WDATA(WDATA), .RINC(RINC), .CLR_ERR(CLR_ERR),
    .RDATA(RDATA), .WFULL(WFULL), .REMPTY(REMPTY), .WAFULL(WAFULL), .RAEMPTY(RAEMPTY),
    .COUNT(COUNT), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;
  assign dut_flags = {WFULL, REMPTY, WAFULL, RAEMPTY, OVF, UDF, COUNT};

  function automatic logic [10:0] model_flags();
    int n = q.size();
    return {n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_udf, 5'(n)};
  endfunction

  task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c);
    bit full = q.size() == 16, empty = q.size() == 0;
    WINC = w; WDATA = d; RINC = r; CLR_ERR = c;
    m_ovf = (w && full) || (m_ovf && !c);
    m_udf = (r && empty) || (m_udf && !c);
    if (r && !empty) void'(q.pop_front());
    if (w && !full) q.push_back(d);
    @(posedge CLK); #1;
    WINC = 0; RINC = 0; CLR_ERR = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; #2; RST = 0;
    q.delete(); m_ovf = 0; m_udf = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (dut_flags !== 11'b01010000000) $display("FAIL reset_state got=%b exp=%b", dut_flags, 11'b01010000000); else passed++;
    WINC = 1; RINC = 1; WDATA = 16'h1234;
    @(posedge CLK); #1;
    total++; if (dut_flags !== 11'b01010000000) $display("FAIL reset_ignores_ops got=%b exp=%b", dut_flags, 11'b01010000000); else passed++;
    @(negedge CLK); RST = 0; WINC = 0; RINC = 0;
    @(posedge CLK); #1;
    step(1, 16'h0055, 0, 0);
    total++; if ({COUNT, RDATA} !== {5'd1, 16'h0055}) $display("FAIL first_edge_write got=%h/%h exp=1/0055", COUNT, RDATA); else passed++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1, 16'(i), 0, 0);
      total++; if ({COUNT, WAFULL, WFULL} !== {5'(i), i >= 14, i == 16}) $display("FAIL fill_%0d got=%0d/%b/%b exp=%0d/%b/%b", i, COUNT, WAFULL, WFULL, i, i >= 14, i == 16); else passed++;
    end
    step(1, 16'h0011, 0, 0);
    total++; if ({OVF, COUNT} !== {1'b1, 5'd16}) $display("FAIL overflow got=%b/%0d exp=1/16", OVF, COUNT); else passed++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      total++; if (RDATA !== 16'(i)) $display("FAIL drain_data_%0d got=%h exp=%h", i, RDATA, 16'(i)); else passed++;
      step(0, 0, 1, 0);
    end
    total++; if (dut_flags !== model_flags()) $display("FAIL drain_flags got=%b exp=%b", dut_flags, model_flags()); else passed++;
    step(0, 0, 1, 0);
    total++; if ({UDF, REMPTY, COUNT} !== {1'b1, 1'b1, 5'd0}) $display("FAIL underflow got=%b/%b/%0d exp=1/1/0", UDF, REMPTY, COUNT); else passed++;
  endtask

  task automatic test_empty_rw();
    do_reset();
    step(1, 16'hABCD, 1, 0);
    total++; if ({UDF, COUNT, RDATA} !== {1'b1, 5'd1, 16'hABCD}) $display("FAIL empty_rw got=%b/%0d/%h exp=1/1/abcd", UDF, COUNT, RDATA); else passed++;
  endtask

  task automatic test_wrap();
    logic [10:0] start;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0);
    start = model_flags();
    for (int i = 0; i < 40; i++) begin
      total++; if (RDATA !== q[0]) $display("FAIL wrap_data_%0d got=%h exp=%h", i, RDATA, q[0]); else passed++;
      step(1, 16'($urandom), 1, 0);
      total++; if (dut_flags !== start) $display("FAIL wrap_flags_%0d got=%b exp=%b", i, dut_flags, start); else passed++;
    end
  endtask

  task automatic test_full_rw();
    logic [15:0] head;
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 16'($urandom), 0, 0);
    head = q[0];
    total++; if (RDATA !== head) $display("FAIL full_rw_head got=%h exp=%h", RDATA, head); else passed++;
    step(1, 16'($urandom), 1, 0);
    total++; if ({OVF, COUNT, WFULL} !== {1'b1, 5'd15, 1'b0}) $display("FAIL full_rw got=%b/%0d/%b exp=1/15/0", OVF, COUNT, WFULL); else passed++;
    total++; if (RDATA !== q[0]) $display("FAIL full_rw_next got=%h exp=%h", RDATA, q[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 16'($urandom), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
    total++; if ({OVF, COUNT} !== {1'b1, 5'd5}) $display("FAIL pre_reset got=%b/%0d exp=1/5", OVF, COUNT); else passed++;
    RST = 1; #2;
    q.delete(); m_ovf = 0; m_udf = 0;
    total++; if (dut_flags !== model_flags()) $display("FAIL async_reset got=%b exp=%b", dut_flags, model_flags()); else passed++;
    RST = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 17; i++) step(1, 16'($urandom), 0, 0);
    step(1, 16'h0, 0, 1);
    total++; if (OVF !== 1'b1) $display("FAIL clr_set_wins got=%b exp=1", OVF); else passed++;
    step(0, 0, 0, 1);
    total++; if (OVF !== 1'b0) $display("FAIL clr_err got=%b exp=0", OVF); else passed++;
  endtask

  task automatic test_random();
    int wb, rb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wb = (i / 100) % 2 ? 30 : 80;
      rb = (i / 100) % 2 ? 80 : 30;
      step($urandom_range(0, 99) < wb, 16'($urandom), $urandom_range(0, 99) < rb, $urandom_range(0, 19) == 0);
      total++; if (dut_flags !== model_flags()) $display("FAIL rand_flags_%0d got=%b exp=%b", i, dut_flags, model_flags()); else passed++;
      if (q.size() > 0) begin
        total++; if (RDATA !== q[0]) $display("FAIL rand_data_%0d got=%h exp=%h", i, RDATA, q[0]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_empty_rw();
    test_wrap();
    test_full_rw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
